// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 receiver definitions: opcodes, addressing modes, reset defaults, command FSM states.
package ssd1306_pkg;

    localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
    localparam logic [7:0] OP_COL_RANGE   = 8'h21;
    localparam logic [7:0] OP_PAGE_RANGE  = 8'h22;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_CHG_PUMP    = 8'h8D;
    localparam logic [7:0] OP_SEG_NORM    = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP   = 8'hA1;
    localparam logic [7:0] OP_RAM_DISP    = 8'hA4;
    localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
    localparam logic [7:0] OP_NORMAL      = 8'hA6;
    localparam logic [7:0] OP_INVERT      = 8'hA7;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
    localparam logic [7:0] OP_DISP_ON     = 8'hAF;
    localparam logic [7:0] OP_COM_NORM    = 8'hC0;
    localparam logic [7:0] OP_COM_FLIP    = 8'hC8;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;

    localparam logic [1:0] ADDR_HORIZ = 2'b00;
    localparam logic [1:0] ADDR_VERT  = 2'b01;
    localparam logic [1:0] ADDR_PAGE  = 2'b10;

    localparam logic [7:0] RST_CONTRAST  = 8'h7F;
    localparam logic [5:0] RST_MUX_RATIO = 6'd63;
    localparam logic [1:0] RST_ADDR_MODE = ADDR_PAGE;
    localparam logic [5:0] MIN_MUX_RATIO = 6'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2
    } cmd_state_t;

    // Total bytes of the command starting with op (0 = not a recognised opcode).
    function automatic logic [1:0] cmd_len(input logic [7:0] op, input logic page_mode);
        casez (op)
            OP_COL_RANGE, OP_PAGE_RANGE:                     cmd_len = 2'd3;
            OP_ADDR_MODE, OP_CONTRAST, OP_CHG_PUMP, OP_MUX_RATIO,
            OP_DISP_OFFSET, OP_CLK_DIV, OP_PRECHARGE, OP_VCOMH: cmd_len = 2'd2;
            OP_SEG_NORM, OP_SEG_REMAP, OP_RAM_DISP, OP_ENTIRE_ON, OP_NORMAL,
            OP_INVERT, OP_DISP_OFF, OP_DISP_ON, OP_COM_NORM, OP_COM_FLIP,
            8'b01??????:                                     cmd_len = 2'd1;
            8'b000?????, 8'b10110???:                        cmd_len = page_mode ? 2'd1 : 2'd0;
            default:                                         cmd_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_deser.sv
// SPI byte deserialiser: synchronisers, SCLK rise detect, MSB-first shifter; byte_valid one cycle after the 8th edge.
// No backpressure (SPI cannot be stalled); frag_err exists only with SSD1306_RX_ERR_EN.
module ssd1306_spi_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       cs,
    input  logic       dc,
`ifdef SSD1306_RX_ERR_EN
    output logic       frag_err,
`endif
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] pins_s;  // {sclk, sdin, cs, dc} after synchronisation
    logic       sclk_prev;
    logic       sclk_rise;
    logic [6:0] shreg;
    logic [2:0] bit_cnt;

    assign pins_s    = sync_q[SYNC_STAGES-1];
    assign sclk_rise = pins_s[3] & ~sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1010;
            sclk_prev  <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            sync_q[0] <= {sclk, sdin, cs, dc};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev  <= pins_s[3];
            byte_valid <= 1'b0;
            if (pins_s[1]) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], pins_s[2]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg, pins_s[2]};
                    byte_dc    <= pins_s[0];
                end
            end
        end
    end

`ifdef SSD1306_RX_ERR_EN
    logic cs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev  <= 1'b1;
            frag_err <= 1'b0;
        end else begin
            cs_prev  <= pins_s[1];
            frag_err <= pins_s[1] & ~cs_prev & (bit_cnt != 3'd0);
        end
    end
`endif

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 4-wire SPI receiver: command decode into display registers, data bytes into GDDRAM write strobes
// one cycle after byte-valid; no backpressure. SSD1306_RX_ERR_EN adds the sticky o_err port.
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_sclk,
    input  logic                           i_sdin,
    input  logic                           i_cs,
    input  logic                           i_dc,
`ifdef SSD1306_RX_ERR_EN
    output logic                           o_err,
`endif
    output logic                           o_wr_en,
    output logic [$clog2(COLS*PAGES)-1:0]  o_wr_addr,
    output logic [7:0]                     o_wr_data,
    output logic                           o_cmd_strobe,
    output logic                           o_display_on,
    output logic [7:0]                     o_contrast,
    output logic                           o_invert,
    output logic                           o_entire_on,
    output logic [5:0]                     o_start_line,
    output logic                           o_seg_remap,
    output logic                           o_com_flip,
    output logic [5:0]                     o_mux_ratio,
    output logic [5:0]                     o_disp_offset,
    output logic                           o_charge_pump,
    output logic [1:0]                     o_addr_mode
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);
    localparam int AW = $clog2(COLS*PAGES);

    logic          byte_valid, byte_dc;
    logic [7:0]    byte_data;
    cmd_state_t    state;
    logic [7:0]    op;
    logic [CW-1:0] arg1, col, col_start, col_end, col_inc, col_nxt;
    logic [PW-1:0] page, page_start, page_end, page_inc, page_nxt;
    logic          page_mode;

`ifdef SSD1306_RX_ERR_EN
    logic frag_err;
`endif

    ssd1306_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (i_sclk),
        .sdin       (i_sdin),
        .cs         (i_cs),
        .dc         (i_dc),
`ifdef SSD1306_RX_ERR_EN
        .frag_err   (frag_err),
`endif
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc)
    );

    assign page_mode = (o_addr_mode == ADDR_PAGE);
    assign col_inc   = (col == col_end)   ? col_start  : col + CW'(1);
    assign page_inc  = (page == page_end) ? page_start : page + PW'(1);

    always_comb begin
        col_nxt  = col;
        page_nxt = page;
        case (o_addr_mode)
            ADDR_HORIZ: begin
                col_nxt = col_inc;
                if (col == col_end) page_nxt = page_inc;
            end
            ADDR_VERT: begin
                page_nxt = page_inc;
                if (page == page_end) col_nxt = col_inc;
            end
            default: col_nxt = col_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op            <= '0;
            arg1          <= '0;
            col           <= '0;
            page          <= '0;
            col_start     <= '0;
            col_end       <= CW'(COLS-1);
            page_start    <= '0;
            page_end      <= PW'(PAGES-1);
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_cmd_strobe  <= 1'b0;
            o_display_on  <= 1'b0;
            o_contrast    <= RST_CONTRAST;
            o_invert      <= 1'b0;
            o_entire_on   <= 1'b0;
            o_start_line  <= '0;
            o_seg_remap   <= 1'b0;
            o_com_flip    <= 1'b0;
            o_mux_ratio   <= RST_MUX_RATIO;
            o_disp_offset <= '0;
            o_charge_pump <= 1'b0;
            o_addr_mode   <= RST_ADDR_MODE;
        end else begin
            o_wr_en      <= 1'b0;
            o_cmd_strobe <= 1'b0;
            if (byte_valid && byte_dc) begin
                // A data byte abandons any half-received command but is still written.
                state     <= ST_IDLE;
                o_wr_en   <= 1'b1;
                o_wr_addr <= AW'(page) * AW'(COLS) + AW'(col);
                o_wr_data <= byte_data;
                col       <= col_nxt;
                page      <= page_nxt;
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        op <= byte_data;
                        case (cmd_len(byte_data, page_mode))
                            2'd1: begin
                                o_cmd_strobe <= 1'b1;
                                casez (byte_data)
                                    OP_DISP_OFF:  o_display_on <= 1'b0;
                                    OP_DISP_ON:   o_display_on <= 1'b1;
                                    OP_RAM_DISP:  o_entire_on  <= 1'b0;
                                    OP_ENTIRE_ON: o_entire_on  <= 1'b1;
                                    OP_NORMAL:    o_invert     <= 1'b0;
                                    OP_INVERT:    o_invert     <= 1'b1;
                                    OP_SEG_NORM:  o_seg_remap  <= 1'b0;
                                    OP_SEG_REMAP: o_seg_remap  <= 1'b1;
                                    OP_COM_NORM:  o_com_flip   <= 1'b0;
                                    OP_COM_FLIP:  o_com_flip   <= 1'b1;
                                    8'b01??????:  o_start_line <= byte_data[5:0];
                                    8'b0000????:  col  <= {col[CW-1:4], byte_data[3:0]};
                                    8'b0001????:  col  <= CW'({byte_data[3:0], col[3:0]});
                                    8'b10110???:  page <= byte_data[PW-1:0];
                                    default: ;
                                endcase
                            end
                            2'd2, 2'd3: state <= ST_ARG1;
                            default: ;
                        endcase
                    end
                    ST_ARG1: begin
                        if (op == OP_COL_RANGE || op == OP_PAGE_RANGE) begin
                            arg1  <= byte_data[CW-1:0];
                            state <= ST_ARG2;
                        end else begin
                            state        <= ST_IDLE;
                            o_cmd_strobe <= 1'b1;
                            case (op)
                                OP_CONTRAST:    o_contrast <= byte_data;
                                OP_ADDR_MODE:   if (byte_data[1:0] != 2'b11) o_addr_mode <= byte_data[1:0];
                                OP_MUX_RATIO:   if (byte_data[5:0] >= MIN_MUX_RATIO) o_mux_ratio <= byte_data[5:0];
                                OP_DISP_OFFSET: o_disp_offset <= byte_data[5:0];
                                OP_CHG_PUMP:    o_charge_pump <= byte_data[2];
                                default: ;
                            endcase
                        end
                    end
                    ST_ARG2: begin
                        state        <= ST_IDLE;
                        o_cmd_strobe <= 1'b1;
                        if (op == OP_COL_RANGE) begin
                            col_start <= arg1;
                            col_end   <= byte_data[CW-1:0];
                            col       <= arg1;
                        end else begin
                            page_start <= arg1[PW-1:0];
                            page_end   <= byte_data[PW-1:0];
                            page       <= arg1[PW-1:0];
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SSD1306_RX_ERR_EN
    logic err_evt;

    always_comb begin
        err_evt = frag_err;
        if (byte_valid) begin
            if (byte_dc)
                err_evt = err_evt | (state != ST_IDLE);
            else if (state == ST_IDLE)
                err_evt = err_evt | (cmd_len(byte_data, page_mode) == 2'd0);
            else if (state == ST_ARG1)
                err_evt = err_evt | (op == OP_ADDR_MODE && byte_data[1:0] == 2'b11)
                                  | (op == OP_MUX_RATIO && byte_data[5:0] < MIN_MUX_RATIO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       o_err <= 1'b0;
        else if (err_evt) o_err <= 1'b1;
    end
`endif

endmodule
